// File: rtl/dom_sqscmul_gf2n_pipe_if.sv
// Valid/ready share bus for the masked GF(2^N) square-scale multiplier.
// The master drives operand shares and randomness; the slave returns result shares.
interface dom_sqscmul_gf2n_pipe_if #(
    parameter int N      = 2,
    parameter int SHARES = 2
);
    localparam int NPAIR = SHARES * (SHARES - 1) / 2;

    logic                    InValidxSI;
    logic                    InReadyxSO;
    logic [N*SHARES-1:0]     _XxDI;
    logic [N*SHARES-1:0]     _YxDI;
    logic [N*NPAIR-1:0]      _ZxDI;
    logic                    OutValidxSO;
    logic                    OutReadyxSI;
    logic [N*SHARES-1:0]     _QxDO;

    modport master (
        output InValidxSI, _XxDI, _YxDI, _ZxDI, OutReadyxSI,
        input  InReadyxSO, OutValidxSO, _QxDO
    );

    modport slave (
        input  InValidxSI, _XxDI, _YxDI, _ZxDI, OutReadyxSI,
        output InReadyxSO, OutValidxSO, _QxDO
    );
endinterface

// File: rtl/dom_sqscmul_gf2n_pipe.sv
// DOM-indep masked Q = X*Y ^ sqsc(X^Y) over GF(2^N) (N = 2 or 4), normal basis.
// Optional randomness-usage counter port RndCntxDO when DOM_SQSCMUL_RND_CNT_EN is defined.
module dom_sqscmul_gf2n_pipe #(
    parameter int N       = 2,
    parameter int SHARES  = 2,
    parameter int OUT_REG = 0
) (
    input  logic ClkxCI,
    input  logic RstxSI,
    dom_sqscmul_gf2n_pipe_if.slave bus_io
`ifdef DOM_SQSCMUL_RND_CNT_EN
    ,
    output logic [31:0] RndCntxDO
`endif
);

    localparam int NPAIR = SHARES * (SHARES - 1) / 2;
    localparam int NTERM = SHARES + 1;  // SHARES product terms plus one sqsc term per domain

    if (N != 2 && N != 4) begin : g_bad_n
        $error("dom_sqscmul_gf2n_pipe: N must be 2 or 4");
    end
    if (SHARES < 2) begin : g_bad_shares
        $error("dom_sqscmul_gf2n_pipe: SHARES must be >= 2");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_oreg
        $error("dom_sqscmul_gf2n_pipe: OUT_REG must be 0 or 1");
    end

    // GF(2^2) normal-basis cells {W^2, W}; identity is 2'b11 and N = W^2.
    function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [1:0] gf4_scl_n(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    function automatic logic [1:0] gf4_scl_n2(input logic [1:0] x);
        return {x[1] ^ x[0], x[1]};
    endfunction

    function automatic logic [1:0] gf4_sqsc(input logic [1:0] x);
        return gf4_scl_n(gf4_sq(x));
    endfunction

    // GF(2^4) built as a tower over the GF(2^2) cells above.
    function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] e;
        e = gf4_scl_n(gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf4_mul(x[3:2], y[3:2]) ^ e, gf4_mul(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic logic [3:0] gf16_sq_scl(input logic [3:0] x);
        return {gf4_sq(x[3:2] ^ x[1:0]), gf4_scl_n2(gf4_sq(x[1:0]))};
    endfunction

    logic [N-1:0]        x_s    [SHARES];
    logic [N-1:0]        y_s    [SHARES];
    logic [N-1:0]        z_s    [NPAIR];
    logic [N-1:0]        term_d [SHARES][NTERM];
    logic [N-1:0]        term_q [SHARES][NTERM];
    logic [N*SHARES-1:0] q_comb;
    logic                v1_q;
    logic                v1_d;
    logic                s1_ready;
    logic                accept;

    for (genvar p = 0; p < NPAIR; p++) begin : g_z
        assign z_s[p] = bus_io._ZxDI[p*N +: N];
    end

    for (genvar i = 0; i < SHARES; i++) begin : g_dom
        assign x_s[i] = bus_io._XxDI[i*N +: N];
        assign y_s[i] = bus_io._YxDI[i*N +: N];

        if (N == 2) begin : g_sq2
            assign term_d[i][SHARES] = gf4_sqsc(x_s[i] ^ y_s[i]);
        end else begin : g_sq4
            assign term_d[i][SHARES] = gf16_sq_scl(x_s[i] ^ y_s[i]);
        end

        for (genvar j = 0; j < SHARES; j++) begin : g_term
            logic [N-1:0] prod;
            if (N == 2) begin : g_m2
                assign prod = gf4_mul(x_s[i], y_s[j]);
            end else begin : g_m4
                assign prod = gf16_mul(x_s[i], y_s[j]);
            end

            if (j == i) begin : g_inner
                assign term_d[i][j] = prod;
            end else begin : g_cross
                localparam int PA = (i < j) ? i : j;
                localparam int PB = (i < j) ? j : i;
                localparam int ZI = PA * SHARES - PA * (PA + 1) / 2 + (PB - PA - 1);
                // Blinded by the pair's Z before the register; never merged with other cross terms here.
                assign term_d[i][j] = prod ^ z_s[ZI];
            end
        end
    end

    assign accept            = bus_io.InValidxSI & s1_ready;
    assign bus_io.InReadyxSO = s1_ready;
    assign v1_d              = s1_ready ? bus_io.InValidxSI : v1_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ClkxCI) begin
        if (RstxSI) begin
            v1_q <= 1'b0;
            // NOTE: the term array is a handful of pipeline flops, not a RAM, so clearing it on reset is cheap and keeps _QxDO at 0.
            for (int i = 0; i < SHARES; i++) begin
                for (int j = 0; j < NTERM; j++) begin
                    term_q[i][j] <= '0;
                end
            end
        end else begin
            v1_q <= v1_d;
            if (accept) begin
                term_q <= term_d;
            end
        end
    end

    // NOTE: q_comb gets a full default before accumulation so no latch is inferred.
    always_comb begin
        q_comb = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < NTERM; j++) begin
                q_comb[i*N +: N] = q_comb[i*N +: N] ^ term_q[i][j];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                v2_q;
        logic                v2_d;
        logic                s2_ready;
        logic                adv2;
        logic [N*SHARES-1:0] q2_q;

        assign s2_ready = ~v2_q | bus_io.OutReadyxSI;
        assign s1_ready = ~v1_q | s2_ready;
        assign adv2     = v1_q & s2_ready;
        assign v2_d     = s2_ready ? v1_q : v2_q;

        always_ff @(posedge ClkxCI) begin
            if (RstxSI) begin
                v2_q <= 1'b0;
                q2_q <= '0;
            end else begin
                v2_q <= v2_d;
                if (adv2) begin
                    q2_q <= q_comb;
                end
            end
        end

        assign bus_io.OutValidxSO = v2_q;
        assign bus_io._QxDO       = q2_q;
    end else begin : g_noreg
        assign s1_ready           = ~v1_q | bus_io.OutReadyxSI;
        assign bus_io.OutValidxSO = v1_q;
        assign bus_io._QxDO       = q_comb;
    end

`ifdef DOM_SQSCMUL_RND_CNT_EN
    localparam logic [32:0] RND_INC = 33'(N * NPAIR);

    logic [31:0] rnd_cnt_q;
    logic [31:0] rnd_cnt_d;
    logic [32:0] rnd_sum;

    // Saturates at all-ones instead of wrapping.
    assign rnd_sum   = {1'b0, rnd_cnt_q} + RND_INC;
    assign rnd_cnt_d = rnd_sum[32] ? 32'hFFFF_FFFF : rnd_sum[31:0];

    always_ff @(posedge ClkxCI) begin
        if (RstxSI) begin
            rnd_cnt_q <= '0;
        end else if (accept) begin
            rnd_cnt_q <= rnd_cnt_d;
        end
    end

    assign RndCntxDO = rnd_cnt_q;
`endif

endmodule

// File: tb/tb_dom_sqscmul_gf2n_pipe.sv
// Self-checking bench: GF(4) 2-share latency-1 instance and GF(16) 3-share latency-2 instance.
// Randomness counter checks are active when DOM_SQSCMUL_RND_CNT_EN is defined.
module tb_dom_sqscmul_gf2n_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dom_sqscmul_gf2n_pipe_if #(.N(2), .SHARES(2)) if2 ();
    dom_sqscmul_gf2n_pipe_if #(.N(4), .SHARES(3)) if4 ();

`ifdef DOM_SQSCMUL_RND_CNT_EN
    logic [31:0] cnt2;
    logic [31:0] cnt4;
`endif

    dom_sqscmul_gf2n_pipe #(.N(2), .SHARES(2), .OUT_REG(0)) u_dut2 (
        .ClkxCI (clk),
        .RstxSI (rst),
        .bus_io (if2)
`ifdef DOM_SQSCMUL_RND_CNT_EN
        ,
        .RndCntxDO (cnt2)
`endif
    );

    dom_sqscmul_gf2n_pipe #(.N(4), .SHARES(3), .OUT_REG(1)) u_dut4 (
        .ClkxCI (clk),
        .RstxSI (rst),
        .bus_io (if4)
`ifdef DOM_SQSCMUL_RND_CNT_EN
        ,
        .RndCntxDO (cnt4)
`endif
    );

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic [1:0] q;
    } vec2_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
    } vec4_t;

    typedef struct packed {
        logic [3:0]  q;
        logic [31:0] cyc;
    } sb_t;

    // GF(4) normal-basis product table, index {a, b}; identity is 2'b11.
    logic [1:0] M4T [16] = '{2'd0, 2'd0, 2'd0, 2'd0,
                             2'd0, 2'd2, 2'd3, 2'd1,
                             2'd0, 2'd3, 2'd1, 2'd2,
                             2'd0, 2'd1, 2'd2, 2'd3};

    // Hand-derived x*y ^ N*(x^y)^2 over GF(4), index {x, y}.
    logic [1:0] Q2EXP [16] = '{2'd0, 2'd1, 2'd3, 2'd2,
                               2'd1, 2'd2, 2'd1, 2'd2,
                               2'd3, 2'd1, 2'd1, 2'd3,
                               2'd2, 2'd2, 2'd3, 2'd3};

    vec2_t       tab2 [16];
    vec4_t       tab4 [7];
    sb_t         sb [$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          acc2    = 0;
    int          acc4    = 0;
    int          out4    = 0;
    logic [31:0] cyc4    = 0;
    logic        chk_lat = 1'b0;
    logic        stall_prev = 1'b0;
    logic [11:0] q_prev  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
        return M4T[{a, b}];
    endfunction

    function automatic logic [3:0] mul16(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] e;
        e = m4(2'd2, m4(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {m4(a[3:2], b[3:2]) ^ e, m4(a[1:0], b[1:0]) ^ e};
    endfunction

    // Square via self-multiply, then scale by nu = 4'h1.
    function automatic logic [3:0] gold16(input logic [3:0] x, input logic [3:0] y);
        return mul16(x, y) ^ mul16(4'h1, mul16(x ^ y, x ^ y));
    endfunction

    function automatic logic [1:0] rec2(input logic [3:0] q);
        return q[1:0] ^ q[3:2];
    endfunction

    function automatic logic [3:0] rec4(input logic [11:0] q);
        return q[3:0] ^ q[7:4] ^ q[11:8];
    endfunction

    task automatic drive2(input logic vld, input logic [1:0] x, input logic [1:0] y);
        logic [1:0] x0, y0;
        x0 = 2'($urandom);
        y0 = 2'($urandom);
        if2.InValidxSI  = vld;
        if2._XxDI       = {x ^ x0, x0};
        if2._YxDI       = {y ^ y0, y0};
        if2._ZxDI       = 2'($urandom);
        if2.OutReadyxSI = 1'b1;
    endtask

    // One cycle on the GF(16) instance: drive at negedge, check, scoreboard, advance to next negedge.
    task automatic step4(input logic vld, input logic [3:0] x, input logic [3:0] y,
                         input logic ordy, input int exp_rdy, input logic [3:0] exp_q);
        logic [3:0] x0, x1, y0, y1;
        sb_t        e;
        x0 = 4'($urandom);
        x1 = 4'($urandom);
        y0 = 4'($urandom);
        y1 = 4'($urandom);
        if4.InValidxSI  = vld;
        if4._XxDI       = {x ^ x0 ^ x1, x1, x0};
        if4._YxDI       = {y ^ y0 ^ y1, y1, y0};
        if4._ZxDI       = 12'($urandom);
        if4.OutReadyxSI = ordy;
        #1;
        if (exp_rdy >= 0) check("in_ready4", 32'(if4.InReadyxSO), 32'(exp_rdy));
        if (stall_prev) begin
            check("q_hold4", 32'(if4._QxDO), 32'(q_prev));
            check("valid_hold4", 32'(if4.OutValidxSO), 32'd1);
        end
        if (if4.OutValidxSO && ordy) begin
            if (sb.size() == 0) begin
                check("spurious_out4", 32'(if4.OutValidxSO), 32'd0);
            end else begin
                e = sb.pop_front();
                out4++;
                check("q4", 32'(rec4(if4._QxDO)), 32'(e.q));
                if (chk_lat) check("latency4", cyc4 - e.cyc, 32'd2);
            end
        end
        stall_prev = if4.OutValidxSO && !ordy;
        q_prev     = if4._QxDO;
        if (vld && if4.InReadyxSO) begin
            sb.push_back('{q: exp_q, cyc: cyc4});
            acc4++;
        end
        @(negedge clk);
        cyc4++;
    endtask

    task automatic drain4();
        for (int k = 0; k < 16 && sb.size() != 0; k++) step4(1'b0, 4'h0, 4'h0, 1'b1, -1, 4'h0);
        check("drain4_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rx, ry;

        for (int k = 0; k < 16; k++) begin
            tab2[k].x = 2'(k >> 2);
            tab2[k].y = 2'(k);
            tab2[k].q = Q2EXP[k];
        end
        tab4[0] = '{x: 4'h0, y: 4'h1, q: 4'hB};
        tab4[1] = '{x: 4'h0, y: 4'h4, q: 4'h8};
        tab4[2] = '{x: 4'h0, y: 4'hF, q: 4'h1};
        tab4[3] = '{x: 4'hF, y: 4'hF, q: 4'hF};
        tab4[4] = '{x: 4'hF, y: 4'h0, q: 4'h1};
        tab4[5] = '{x: 4'h1, y: 4'h1, q: 4'h7};
        tab4[6] = '{x: 4'h0, y: 4'h0, q: 4'h0};

        rst = 1'b1;
        if2.InValidxSI = 1'b0; if2._XxDI = '0; if2._YxDI = '0; if2._ZxDI = '0; if2.OutReadyxSI = 1'b1;
        if4.InValidxSI = 1'b0; if4._XxDI = '0; if4._YxDI = '0; if4._ZxDI = '0; if4.OutReadyxSI = 1'b1;

        // Reset for three cycles, then one all-zero accept.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid2", 32'(if2.OutValidxSO), 32'd0);
        check("rst_q2", 32'(if2._QxDO), 32'd0);
        check("rst_in_ready2", 32'(if2.InReadyxSO), 32'd1);
        check("rst_out_valid4", 32'(if4.OutValidxSO), 32'd0);
        check("rst_q4", 32'(if4._QxDO), 32'd0);
        check("rst_in_ready4", 32'(if4.InReadyxSO), 32'd1);
        if2.InValidxSI = 1'b1;
        acc2++;
        @(negedge clk);
        check("zero_out_valid2", 32'(if2.OutValidxSO), 32'd1);
        check("zero_q2", 32'(rec2(if2._QxDO)), 32'd0);

        // Exhaustive GF(4), streaming one result per cycle.
        for (int k = 0; k < 16; k++) begin
            drive2(1'b1, tab2[k].x, tab2[k].y);
            #1;
            check("in_ready2", 32'(if2.InReadyxSO), 32'd1);
            acc2++;
            @(negedge clk);
            check("out_valid2", 32'(if2.OutValidxSO), 32'd1);
            check("q2", 32'(rec2(if2._QxDO)), 32'(tab2[k].q));
        end
        drive2(1'b0, 2'd0, 2'd0);
`ifdef DOM_SQSCMUL_RND_CNT_EN
        check("rnd_cnt2", cnt2, 32'(2 * acc2));
`endif
        @(negedge clk);
        check("idle_out_valid2", 32'(if2.OutValidxSO), 32'd0);

        // GF(16): hand vectors, then all 256 pairs against the model, latency 2.
        chk_lat = 1'b1;
        for (int k = 0; k < 7; k++) step4(1'b1, tab4[k].x, tab4[k].y, 1'b1, 1, tab4[k].q);
        for (int k = 0; k < 256; k++) begin
            rx = 4'(k >> 4);
            ry = 4'(k);
            step4(1'b1, rx, ry, 1'b1, 1, gold16(rx, ry));
        end
        drain4();
        chk_lat = 1'b0;

        // Backpressure: five stalled cycles with valid held high and data changing.
        acc4 = 0;
        out4 = 0;
        for (int c = 0; c < 5; c++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            step4(1'b1, rx, ry, 1'b0, (c < 2) ? 1 : 0, gold16(rx, ry));
        end
        for (int c = 0; c < 4; c++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            step4(1'b1, rx, ry, 1'b1, -1, gold16(rx, ry));
        end
        drain4();
        check("bp_no_loss4", 32'(out4), 32'(acc4));

        // Reset while two results are in flight.
        for (int c = 0; c < 2; c++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            step4(1'b1, rx, ry, 1'b1, -1, gold16(rx, ry));
        end
        rst = 1'b1;
        if4.InValidxSI = 1'b0;
        @(negedge clk);
        cyc4++;
        check("midrst_out_valid4", 32'(if4.OutValidxSO), 32'd0);
        check("midrst_q4", 32'(if4._QxDO), 32'd0);
        check("midrst_out_valid2", 32'(if2.OutValidxSO), 32'd0);
        rst = 1'b0;
        sb.delete();
        stall_prev = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step4(1'b0, 4'h0, 4'h0, 1'b1, -1, 4'h0);
            check("post_rst_out_valid4", 32'(if4.OutValidxSO), 32'd0);
        end

`ifdef DOM_SQSCMUL_RND_CNT_EN
        // Ten accepts interleaved with idle and stall cycles; 12 random bits per accept.
        check("rnd_cnt4_clear", cnt4, 32'd0);
        acc4 = 0;
        for (int k = 0; k < 80 && acc4 < 10; k++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            step4((k % 3) != 1, rx, ry, (k % 4) != 3, -1, gold16(rx, ry));
        end
        check("rnd_cnt4", cnt4, 32'd120);
        drain4();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
